id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.

---
 rtl/id_ex_stage_if.sv | 61 ++++++
 rtl/id_ex_stage.sv | 109 ++++++++++
 tb/tb_id_ex_stage.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID-stage fields in, registered EX-stage copies and stall status out.
// The master side is the decode stage; the slave side is the ID/EX register.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              id_mem_to_reg;
  logic              id_alu_src;
  logic [3:0]        id_alu_op;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic [DATA_W-1:0] id_imm;

  logic              ex_valid;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic              ex_uses_rs;
  logic              ex_uses_rt;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_alu_src;
  logic [3:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;

  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
           id_alu_op, id_rs_data, id_rt_data, id_imm,
    input  ex_valid, ex_rs, ex_rt, ex_uses_rs, ex_uses_rt, ex_dst,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
           ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, stall, stall_count
  );

  modport slave (
    input  flush, id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
           id_alu_op, id_rs_data, id_rt_data, id_imm,
    output ex_valid, ex_rs, ex_rt, ex_uses_rs, ex_uses_rt, ex_dst,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
           ex_alu_op, ex_rs_data, ex_rt_data, ex_imm, stall, stall_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection on stall/flush,
// and a saturating stall-cycle counter for performance debug.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic           clk,
  input  logic           rst,
  id_ex_stage_if.slave   bus
);

  logic              exValidReg;
  logic [REG_AW-1:0] exRsReg;
  logic [REG_AW-1:0] exRtReg;
  logic              exUsesRsReg;
  logic              exUsesRtReg;
  logic [REG_AW-1:0] exDstReg;
  logic              exRegWriteReg;
  logic              exMemReadReg;
  logic              exMemWriteReg;
  logic              exMemToRegReg;
  logic              exAluSrcReg;
  logic [3:0]        exAluOpReg;
  logic [DATA_W-1:0] exRsDataReg;
  logic [DATA_W-1:0] exRtDataReg;
  logic [DATA_W-1:0] exImmReg;
  logic [CNT_W-1:0]  stallCountReg;

  logic rsMatch;
  logic rtMatch;
  logic hazard;
  logic stallNow;
  logic bubble;
  logic ctrlKeep;

  // A load in EX whose destination is read by the ID instruction; $0 is never a real producer.
  assign rsMatch  = bus.id_uses_rs && (bus.id_rs == exDstReg);
  assign rtMatch  = bus.id_uses_rt && (bus.id_rt == exDstReg);
  assign hazard   = exValidReg && exMemReadReg && (exDstReg != '0) && bus.id_valid &&
                    (rsMatch || rtMatch);
  assign stallNow = hazard && !bus.flush && !rst;
  assign bubble   = bus.flush || stallNow;
  assign ctrlKeep = bus.id_valid;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      exValidReg    <= 1'b0;
      exRsReg       <= '0;
      exRtReg       <= '0;
      exUsesRsReg   <= 1'b0;
      exUsesRtReg   <= 1'b0;
      exDstReg      <= '0;
      exRegWriteReg <= 1'b0;
      exMemReadReg  <= 1'b0;
      exMemWriteReg <= 1'b0;
      exMemToRegReg <= 1'b0;
      exAluSrcReg   <= 1'b0;
      exAluOpReg    <= '0;
      exRsDataReg   <= '0;
      exRtDataReg   <= '0;
      exImmReg      <= '0;
    end else begin
      // An invalid ID slot still moves its indices/data, but may never write or access memory.
      exValidReg    <= bus.id_valid;
      exRsReg       <= bus.id_rs;
      exRtReg       <= bus.id_rt;
      exDstReg      <= bus.id_dst;
      exRsDataReg   <= bus.id_rs_data;
      exRtDataReg   <= bus.id_rt_data;
      exImmReg      <= bus.id_imm;
      exUsesRsReg   <= ctrlKeep && bus.id_uses_rs;
      exUsesRtReg   <= ctrlKeep && bus.id_uses_rt;
      exRegWriteReg <= ctrlKeep && bus.id_reg_write;
      exMemReadReg  <= ctrlKeep && bus.id_mem_read;
      exMemWriteReg <= ctrlKeep && bus.id_mem_write;
      exMemToRegReg <= ctrlKeep && bus.id_mem_to_reg;
      exAluSrcReg   <= ctrlKeep && bus.id_alu_src;
      exAluOpReg    <= ctrlKeep ? bus.id_alu_op : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallCountReg <= '0;
    end else if (stallNow && (stallCountReg != {CNT_W{1'b1}})) begin
      stallCountReg <= stallCountReg + 1'b1;
    end
  end

  assign bus.ex_valid      = exValidReg;
  assign bus.ex_rs         = exRsReg;
  assign bus.ex_rt         = exRtReg;
  assign bus.ex_uses_rs    = exUsesRsReg;
  assign bus.ex_uses_rt    = exUsesRtReg;
  assign bus.ex_dst        = exDstReg;
  assign bus.ex_reg_write  = exRegWriteReg;
  assign bus.ex_mem_read   = exMemReadReg;
  assign bus.ex_mem_write  = exMemWriteReg;
  assign bus.ex_mem_to_reg = exMemToRegReg;
  assign bus.ex_alu_src    = exAluSrcReg;
  assign bus.ex_alu_op     = exAluOpReg;
  assign bus.ex_rs_data    = exRsDataReg;
  assign bus.ex_rt_data    = exRtDataReg;
  assign bus.ex_imm        = exImmReg;
  assign bus.stall         = stallNow;
  assign bus.stall_count   = stallCountReg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios with literal expectations, then random
// instruction streams checked every cycle against a behavioural pipeline model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        usesRs;
    logic        usesRt;
    logic [4:0]  dst;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic        aluSrc;
    logic [3:0]  aluOp;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] imm;
  } instT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  instT mdlEx = '0;
  int   mdlCnt16 = 0;
  int   mdlCnt4 = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) busA ();
  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  busB ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dutA (.clk(clk), .rst(rst), .bus(busA));
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4))  dutB (.clk(clk), .rst(rst), .bus(busB));

  // The narrow-counter instance sees exactly the same instruction stream.
  assign busB.flush         = busA.flush;
  assign busB.id_valid      = busA.id_valid;
  assign busB.id_rs         = busA.id_rs;
  assign busB.id_rt         = busA.id_rt;
  assign busB.id_uses_rs    = busA.id_uses_rs;
  assign busB.id_uses_rt    = busA.id_uses_rt;
  assign busB.id_dst        = busA.id_dst;
  assign busB.id_reg_write  = busA.id_reg_write;
  assign busB.id_mem_read   = busA.id_mem_read;
  assign busB.id_mem_write  = busA.id_mem_write;
  assign busB.id_mem_to_reg = busA.id_mem_to_reg;
  assign busB.id_alu_src    = busA.id_alu_src;
  assign busB.id_alu_op     = busA.id_alu_op;
  assign busB.id_rs_data    = busA.id_rs_data;
  assign busB.id_rt_data    = busA.id_rt_data;
  assign busB.id_imm        = busA.id_imm;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input instT p, input logic fl);
    busA.flush         = fl;
    busA.id_valid      = p.valid;
    busA.id_rs         = p.rs;
    busA.id_rt         = p.rt;
    busA.id_uses_rs    = p.usesRs;
    busA.id_uses_rt    = p.usesRt;
    busA.id_dst        = p.dst;
    busA.id_reg_write  = p.regWrite;
    busA.id_mem_read   = p.memRead;
    busA.id_mem_write  = p.memWrite;
    busA.id_mem_to_reg = p.memToReg;
    busA.id_alu_src    = p.aluSrc;
    busA.id_alu_op     = p.aluOp;
    busA.id_rs_data    = p.rsData;
    busA.id_rt_data    = p.rtData;
    busA.id_imm        = p.imm;
  endtask

  function automatic instT curId();
    instT p;
    p = '{valid: busA.id_valid, rs: busA.id_rs, rt: busA.id_rt, usesRs: busA.id_uses_rs,
          usesRt: busA.id_uses_rt, dst: busA.id_dst, regWrite: busA.id_reg_write,
          memRead: busA.id_mem_read, memWrite: busA.id_mem_write, memToReg: busA.id_mem_to_reg,
          aluSrc: busA.id_alu_src, aluOp: busA.id_alu_op, rsData: busA.id_rs_data,
          rtData: busA.id_rt_data, imm: busA.id_imm};
    return p;
  endfunction

  function automatic instT dutEx(input logic useB);
    instT p;
    if (useB)
      p = '{valid: busB.ex_valid, rs: busB.ex_rs, rt: busB.ex_rt, usesRs: busB.ex_uses_rs,
            usesRt: busB.ex_uses_rt, dst: busB.ex_dst, regWrite: busB.ex_reg_write,
            memRead: busB.ex_mem_read, memWrite: busB.ex_mem_write, memToReg: busB.ex_mem_to_reg,
            aluSrc: busB.ex_alu_src, aluOp: busB.ex_alu_op, rsData: busB.ex_rs_data,
            rtData: busB.ex_rt_data, imm: busB.ex_imm};
    else
      p = '{valid: busA.ex_valid, rs: busA.ex_rs, rt: busA.ex_rt, usesRs: busA.ex_uses_rs,
            usesRt: busA.ex_uses_rt, dst: busA.ex_dst, regWrite: busA.ex_reg_write,
            memRead: busA.ex_mem_read, memWrite: busA.ex_mem_write, memToReg: busA.ex_mem_to_reg,
            aluSrc: busA.ex_alu_src, aluOp: busA.ex_alu_op, rsData: busA.ex_rs_data,
            rtData: busA.ex_rt_data, imm: busA.ex_imm};
    return p;
  endfunction

  // Load-use rule: the instruction waiting in ID reads the register a load in EX will produce.
  function automatic logic modelStall(input instT ex, input instT id, input logic fl, input logic r);
    logic readsIt;
    readsIt = (id.usesRs && id.rs == ex.dst) || (id.usesRt && id.rt == ex.dst);
    return !r && !fl && ex.valid && ex.memRead && (ex.dst != 5'd0) && id.valid && readsIt;
  endfunction

  task automatic modelEdge();
    instT id;
    logic s;
    id = curId();
    if (rst) begin
      mdlEx = '0;
      mdlCnt16 = 0;
      mdlCnt4 = 0;
    end else begin
      s = modelStall(mdlEx, id, busA.flush, rst);
      if (s) begin
        mdlCnt16 = (mdlCnt16 < 65535) ? mdlCnt16 + 1 : 65535;
        mdlCnt4  = (mdlCnt4 < 15) ? mdlCnt4 + 1 : 15;
      end
      if (s || busA.flush) begin
        mdlEx = '0;
      end else begin
        mdlEx = id;
        if (!id.valid) begin
          mdlEx.usesRs = 0; mdlEx.usesRt = 0; mdlEx.regWrite = 0; mdlEx.memRead = 0;
          mdlEx.memWrite = 0; mdlEx.memToReg = 0; mdlEx.aluSrc = 0; mdlEx.aluOp = 4'd0;
        end
      end
    end
  endtask

  // Compare process: model advances on each rising edge, outputs checked on the falling edge.
  initial begin
    @(posedge clk);
    forever begin
      modelEdge();
      @(negedge clk);
      check("ex_regs_A", 128'(dutEx(1'b0)), 128'(mdlEx));
      check("ex_regs_B", 128'(dutEx(1'b1)), 128'(mdlEx));
      check("stall", 128'(busA.stall), 128'(modelStall(mdlEx, curId(), busA.flush, rst)));
      check("stall_B", 128'(busB.stall), 128'(busA.stall));
      check("stall_count16", 128'(busA.stall_count), 128'(mdlCnt16));
      check("stall_count4", 128'(busB.stall_count), 128'(mdlCnt4));
      @(posedge clk);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    instT p;
    drive('0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check("reset_ex_valid", 128'(busA.ex_valid), 128'(0));
    check("reset_ex_all", 128'(dutEx(1'b0)), 128'(0));
    check("reset_stall", 128'(busA.stall), 128'(0));
    check("reset_count", 128'(busA.stall_count), 128'(0));
    rst = 1'b0;

    // lw $t0 then a consumer of $t0: one bubble, then the consumer enters EX.
    p = '0; p.valid = 1; p.memRead = 1; p.regWrite = 1; p.memToReg = 1; p.dst = 5'd8;
    drive(p, 1'b0);
    tick();
    p = '0; p.valid = 1; p.usesRs = 1; p.rs = 5'd8; p.dst = 5'd10; p.regWrite = 1;
    drive(p, 1'b0);
    #1 check("lu_stall", 128'(busA.stall), 128'(1));
    tick();
    check("lu_bubble_valid", 128'(busA.ex_valid), 128'(0));
    check("lu_count", 128'(busA.stall_count), 128'(1));
    #1 check("lu_stall_drop", 128'(busA.stall), 128'(0));
    tick();
    check("lu_ex_rs", 128'(busA.ex_rs), 128'(8));
    check("lu_ex_valid", 128'(busA.ex_valid), 128'(1));
    check("lu_count_hold", 128'(busA.stall_count), 128'(1));

    // Load to $0 never stalls.
    p = '0; p.valid = 1; p.memRead = 1; p.regWrite = 1; p.dst = 5'd0;
    drive(p, 1'b0);
    tick();
    p = '0; p.valid = 1; p.usesRs = 1; p.rs = 5'd0; p.dst = 5'd10; p.regWrite = 1;
    drive(p, 1'b0);
    #1 check("zero_no_stall", 128'(busA.stall), 128'(0));
    tick();
    check("zero_ex_dst", 128'(busA.ex_dst), 128'(10));

    // Flush wins over a hazard in the same cycle.
    p = '0; p.valid = 1; p.memRead = 1; p.regWrite = 1; p.dst = 5'd8;
    drive(p, 1'b0);
    tick();
    p = '0; p.valid = 1; p.usesRs = 1; p.rs = 5'd8; p.dst = 5'd10; p.regWrite = 1;
    drive(p, 1'b1);
    #1 check("flush_no_stall", 128'(busA.stall), 128'(0));
    tick();
    check("flush_bubble", 128'(busA.ex_valid), 128'(0));
    check("flush_count", 128'(busA.stall_count), 128'(1));

    // ALU producer: no stall, data passes through.
    p = '0; p.valid = 1; p.regWrite = 1; p.dst = 5'd9; p.aluOp = 4'd2;
    drive(p, 1'b0);
    tick();
    p = '0; p.valid = 1; p.usesRt = 1; p.rt = 5'd9; p.dst = 5'd11; p.rtData = 32'hDEADBEEF;
    drive(p, 1'b0);
    #1 check("alu_no_stall", 128'(busA.stall), 128'(0));
    tick();
    check("alu_rt_data", 128'(busA.ex_rt_data), 128'(32'hDEADBEEF));

    // Back-to-back dependent loads: every other edge stalls, 20 stalls in 40 edges.
    p = '0; p.valid = 1; p.memRead = 1; p.regWrite = 1; p.usesRs = 1; p.rs = 5'd8; p.dst = 5'd8;
    drive(p, 1'b0);
    for (int i = 0; i < 40; i++) tick();
    check("sat_count16", 128'(busA.stall_count), 128'(21));
    check("sat_count4", 128'(busB.stall_count), 128'(15));
    tick();
    check("mid_stall_pre", 128'(busA.stall), 128'(1));
    rst = 1'b1;
    #1 check("mid_stall_rst", 128'(busA.stall), 128'(0));
    tick();
    check("mid_rst_valid", 128'(busA.ex_valid), 128'(0));
    check("mid_rst_count", 128'(busA.stall_count), 128'(0));
    rst = 1'b0;

    // Random streams over a small register window so loads and consumers collide often.
    for (int i = 0; i < 3000; i++) begin
      p.valid    = ($urandom_range(0, 7) != 0);
      p.rs       = 5'($urandom_range(0, 3));
      p.rt       = 5'($urandom_range(0, 3));
      p.usesRs   = 1'($urandom);
      p.usesRt   = 1'($urandom);
      p.dst      = 5'($urandom_range(0, 3));
      p.regWrite = 1'($urandom);
      p.memRead  = ($urandom_range(0, 2) == 0);
      p.memWrite = 1'($urandom);
      p.memToReg = 1'($urandom);
      p.aluSrc   = 1'($urandom);
      p.aluOp    = 4'($urandom);
      p.rsData   = $urandom;
      p.rtData   = $urandom;
      p.imm      = $urandom;
      drive(p, ($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 96) == 0);
      tick();
    end
    rst = 1'b0;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
